micro_run_ctrl: RTL
===================

# micro_run_ctrl

Synthesizable run controller for the Microprocesador core. It sequences the CPU's reset and run phases and watches the CPU's program counter and memory-write bus. It ends each run with a pass, fail, halt or timeout verdict and reports the cycle count. It sits between the top-level Clk/Reset and the core, so one FPGA image or one bench can run programs repeatedly with a reported result and no manual stimulus.

## Interface
Parameters:
- PC_W, 8: program-counter width.
- ADDR_W, 8: data-memory address width.
- DATA_W, 8: data-memory write-data width.
- CNT_W, 16: cycle-counter width.
- RST_HOLD, 4: number of cycles `cpu_rst` is held high before a run (≥1).
- TIMEOUT, 1000: maximum number of RUN cycles (≥2, < 2^CNT_W).
- STALL_CYCLES, 3: number of consecutive unchanged-PC compares that declare a halt (≥1).
- MAILBOX_ADDR, 8'hFF: address the program writes its verdict to.
- PASS_CODE, 8'h01: mailbox value that means pass.

Ports:
- Clk, in, 1: the single clock; all logic is on the rising edge.
- Reset, in, 1: asynchronous, active-high reset.
- start, in, 1: single-cycle request to begin a run.
- pc, in, PC_W: the core's program counter.
- mem_we, in, 1: the core's data-memory write enable.
- mem_addr, in, ADDR_W: the core's write address.
- mem_wdata, in, DATA_W: the core's write data.
- cpu_rst, out, 1: reset to the core.
- running, out, 1: high during the RUN state.
- done, out, 1: high during the DONE state.
- status, out, 3: 0 NONE, 1 PASS, 2 FAIL, 3 HALT, 4 TIMEOUT.
- cycles, out, CNT_W: number of RUN cycles elapsed.
- result, out, DATA_W: the captured mailbox value.

## Operation
- Reset values: state IDLE, `cpu_rst`=1, `running`=0, `done`=0, `status`=0, `cycles`=0, `result`=0, hold counter 0, stall counter 0.
- IDLE: `cpu_rst`=1.
  - `start`=1 → RST_HOLD; clears `status`, `cycles`, `result`.
- RST_HOLD: `cpu_rst`=1 for exactly RST_HOLD cycles, then → RUN.
- RUN: `cpu_rst`=0, `running`=1, `cycles` increments by 1 every cycle. Terminating events are evaluated each cycle in this priority:
  - Mailbox: `mem_we`=1 and `mem_addr`==MAILBOX_ADDR → capture `mem_wdata` into `result`. The verdict is PASS if the value equals PASS_CODE, otherwise FAIL.
  - Stall: `pc` is compared with its value in the previous RUN cycle. Each equal compare increments the stall counter; any change clears it. The first RUN cycle has no previous value and does not compare. A counter value of STALL_CYCLES → HALT.
  - Timeout: the RUN cycle in which `cycles` is TIMEOUT-1 before increment → TIMEOUT.
- On an event: → DONE and latch `status`. `cycles` includes the event cycle.
- DONE: `done`=1 and `cpu_rst`=1, so the core is frozen. `status`, `cycles` and `result` hold.
  - `start`=1 → RST_HOLD, which starts a new run.
- `start` is ignored in RST_HOLD and RUN.
- `Reset` at any time, including mid-run, forces the reset values immediately (asynchronous). A run is never resumed after reset.
- Counters never wrap. TIMEOUT < 2^CNT_W guarantees this.

## Timing
- `start` sampled in cycle t → `cpu_rst` stays 1 through cycle t+RST_HOLD. `running`=1 from cycle t+1+RST_HOLD.
- Event in RUN cycle e → `done`, `status` and `result` are valid from cycle e+1. `running`=0 and `cpu_rst`=1 from cycle e+1.
- HALT needs `pc` constant for STALL_CYCLES+1 consecutive RUN cycles.
- A mailbox write in the same cycle as a stall or timeout event yields PASS/FAIL.
- A stall and a timeout in the same cycle yield HALT.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `MICRO_RUN_STALL_DET_EN`
  - Defined: stall detection and the HALT status are present.
  - Undefined: the stall compare logic and counter are removed. Runs end only on a mailbox write or timeout, and status 3 never occurs. Use this for programs with intentional tight loops.

## Structure
- Package `micro_run_pkg` holds:
  - The state encoding: IDLE, RST_HOLD, RUN, DONE.
  - The status codes: ST_NONE, ST_PASS, ST_FAIL, ST_HALT, ST_TIMEOUT.
- One sub-module, `micro_pc_stall_det`: the registered previous-PC value, the equal-compare counter and the halt flag, with clear on RUN entry. It is instantiated only under `MICRO_RUN_STALL_DET_EN`.
- The FSM, cycle counter and mailbox capture stay in `micro_run_ctrl`.

## Test plan
All scenarios use default parameters.
- Reset then `start`: `cpu_rst` is 1 for 4 cycles, then `running`=1. PC increments every cycle. A write of 8'h01 to 8'hFF in RUN cycle 10 → `done`, `status`=1, `result`=8'h01, `cycles`=10.
- Write of 8'h5A to 8'hFF in RUN cycle 7 → `status`=2, `result`=8'h5A, `cycles`=7. A write to 8'hFE earlier in the run is ignored.
- PC held at 8'h20 from RUN cycle 5 → `status`=3 with `cycles`=8. Repeat with the macro undefined → run continues, then `status`=4 with `cycles`=1000.
- PC always changing and no mailbox write → `status`=4 with `cycles`=1000. Check that `done` rises exactly one cycle after the 1000th RUN cycle.
- A mailbox write on the same cycle that the stall count reaches 3 → `status`=PASS or FAIL according to the data, never HALT.
- Assert `Reset` in RUN cycle 50 → all outputs immediately at their reset values. Then `start` → a fresh run with `cycles` restarting at 0. A second `start` from DONE also reruns cleanly.

Source files
------------

// File: rtl/micro_run_pkg.sv
// rtl/micro_run_pkg.sv - shared state and status encodings for micro_run_ctrl
//
// Purpose: FSM state encoding and run verdict codes used by the run controller.
package micro_run_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RST_HOLD = 2'd1,
    S_RUN      = 2'd2,
    S_DONE     = 2'd3
  } run_state_e;

  typedef enum logic [2:0] {
    ST_NONE    = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_HALT    = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_status_e;

endpackage

// File: rtl/micro_pc_stall_det.sv
// rtl/micro_pc_stall_det.sv - detects a program counter that stops changing
//
// Purpose: remembers the previous RUN-cycle PC and counts consecutive equal
//          compares; flags a halt on the compare that reaches STALL_CYCLES.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   i_clear    - drop the stored PC and counter (held while not running)
//   i_en       - current cycle is a RUN cycle
//   i_pc       - core program counter
//   o_halt     - this RUN cycle completes STALL_CYCLES equal compares
module micro_pc_stall_det #(
  parameter int PC_W         = 8,
  parameter int STALL_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_en,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_halt
);

  localparam int SC_W = $clog2(STALL_CYCLES + 1);

  logic [PC_W-1:0] r_prev_pc;
  logic            r_prev_vld;
  logic [SC_W-1:0] r_cnt;
  logic            w_same;

  // The first RUN cycle has no valid previous PC, so it never counts as a compare.
  assign w_same = i_en && r_prev_vld && (i_pc == r_prev_pc);
  assign o_halt = w_same && (r_cnt == SC_W'(STALL_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_pc  <= '0;
      r_prev_vld <= 1'b0;
      r_cnt      <= '0;
    end else if (i_clear) begin
      r_prev_vld <= 1'b0;
      r_cnt      <= '0;
    end else if (i_en) begin
      r_prev_pc  <= i_pc;
      r_prev_vld <= 1'b1;
      if (!w_same)
        r_cnt <= '0;
      else if (r_cnt != SC_W'(STALL_CYCLES))
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/micro_run_ctrl.sv
// rtl/micro_run_ctrl.sv - reset/run sequencer with pass/fail/halt/timeout verdict
//
// Purpose: holds the core in reset, runs it, and ends the run on a mailbox
//          write, a stalled PC or a cycle timeout; reports verdict and cycles.
// Optional feature macro: MICRO_RUN_STALL_DET_EN (stall detection / HALT).
// Ports:
//   Clk, Reset                  - clock, asynchronous active-high reset
//   start                       - one-cycle run request (IDLE or DONE only)
//   pc, mem_we, mem_addr,
//   mem_wdata                   - observed core PC and data-memory write bus
//   cpu_rst, running, done      - core reset and phase indicators
//   status, cycles, result      - verdict, RUN cycle count, mailbox value
module micro_run_ctrl
  import micro_run_pkg::*;
#(
  parameter int                 PC_W         = 8,
  parameter int                 ADDR_W       = 8,
  parameter int                 DATA_W       = 8,
  parameter int                 CNT_W        = 16,
  parameter int                 RST_HOLD     = 4,
  parameter int                 TIMEOUT      = 1000,
  parameter int                 STALL_CYCLES = 3,
  parameter logic [ADDR_W-1:0]  MAILBOX_ADDR = 8'hFF,
  parameter logic [DATA_W-1:0]  PASS_CODE    = 8'h01
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [PC_W-1:0]   pc,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              running,
  output logic              done,
  output logic [2:0]        status,
  output logic [CNT_W-1:0]  cycles,
  output logic [DATA_W-1:0] result
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  run_state_e        r_state, w_state_nxt;
  run_status_e       r_status, w_status_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [CNT_W-1:0]  r_cycles;
  logic [DATA_W-1:0] r_result;
  logic              r_cpu_rst, r_running, r_done;
  logic              w_start_ok, w_hold_last, w_mbox, w_halt, w_tmo;

  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_hold_last = (r_hold == HOLD_W'(RST_HOLD - 1));
  assign w_mbox      = mem_we && (mem_addr == MAILBOX_ADDR);
  assign w_tmo       = (r_cycles == CNT_W'(TIMEOUT - 1));

`ifdef MICRO_RUN_STALL_DET_EN
  micro_pc_stall_det #(
    .PC_W         (PC_W),
    .STALL_CYCLES (STALL_CYCLES)
  ) u_stall_det (
    .clk     (Clk),
    .rst     (Reset),
    .i_clear (r_state != S_RUN),
    .i_en    (r_state == S_RUN),
    .i_pc    (pc),
    .o_halt  (w_halt)
  );
`else
  logic w_unused_pc;
  assign w_unused_pc = ^pc;
  assign w_halt      = 1'b0;
`endif

  // Next state and verdict. Mailbox beats stall, stall beats timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt  = S_RST_HOLD;
          w_status_nxt = ST_NONE;
        end
      end
      S_RST_HOLD: begin
        if (w_hold_last)
          w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_mbox) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = (mem_wdata == PASS_CODE) ? ST_PASS : ST_FAIL;
        end else if (w_halt) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = ST_HALT;
        end else if (w_tmo) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = ST_TIMEOUT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Phase outputs are registered from the next state so they change with it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_status  <= ST_NONE;
      r_cpu_rst <= 1'b1;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_status  <= w_status_nxt;
      r_cpu_rst <= (w_state_nxt != S_RUN);
      r_running <= (w_state_nxt == S_RUN);
      r_done    <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hold   <= '0;
      r_cycles <= '0;
      r_result <= '0;
    end else begin
      r_hold <= (r_state == S_RST_HOLD) ? r_hold + 1'b1 : '0;
      if (w_start_ok) begin
        r_cycles <= '0;
        r_result <= '0;
      end else if (r_state == S_RUN) begin
        // The event cycle itself is counted; TIMEOUT < 2^CNT_W so no wrap.
        r_cycles <= r_cycles + 1'b1;
        if (w_mbox)
          r_result <= mem_wdata;
      end
    end
  end

  assign cpu_rst = r_cpu_rst;
  assign running = r_running;
  assign done    = r_done;
  assign status  = r_status;
  assign cycles  = r_cycles;
  assign result  = r_result;

endmodule
